// File: rtl/twiddle_load_ctrl.sv
// -----------------------------------------------------------------------------
// twiddle_load_ctrl
//
// Sequencer that fills the full-parallel FFT twiddle weight shift buffer from a
// synchronous twiddle ROM. On an accepted start request it reads all
// NW = NPOINT * 2^(NPOINT-1) complex weights in descending address order and
// emits them as a valid-qualified stream. The buffer shifts in at its LSB end,
// so address 0 enters last and lands in slice 0, and address NW-1 lands in
// slice NW-1. A load never begins while the FFT core is computing. Once a load
// has begun it runs to completion.
//
// Ports
//   clk               in   single clock, rising edge
//   rst_n             in   asynchronous reset, active low
//   start             in   load request, sampled every cycle
//   fft_busy          in   FFT core computing; holds off the start of a load
//   rom_rd_en         out  ROM read strobe
//   rom_addr          out  ROM read address (AW bits)
//   rom_data_real     in   ROM real data, valid one cycle after rom_rd_en
//   rom_data_imag     in   ROM imag data, same timing
//   dout_weight_valid out  shift strobe to the weight buffer
//   dout_weight_real  out  registered weight, real part
//   dout_weight_imag  out  registered weight, imag part
//   busy              out  load in progress (WAIT, READ or DRAIN)
//   done              out  one-cycle pulse after the last weight is shifted
//   weight_ready      out  buffer holds a complete, coherent weight set
//
// Timeline with start accepted in cycle 0 and fft_busy low:
//   READ cycles 1..NW (addresses NW-1..0), ROM data in cycles 2..NW+1,
//   dout_weight_valid in cycles 3..NW+2, done/weight_ready in cycle NW+3.
// -----------------------------------------------------------------------------
module twiddle_load_ctrl #(
  parameter  int NPOINT = 3,
  parameter  int WIDTH  = 16,
  localparam int NW     = NPOINT * (1 << (NPOINT - 1)),
  localparam int AW     = $clog2(NW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             fft_busy,
  output logic             rom_rd_en,
  output logic [AW-1:0]    rom_addr,
  input  logic [WIDTH-1:0] rom_data_real,
  input  logic [WIDTH-1:0] rom_data_imag,
  output logic             dout_weight_valid,
  output logic [WIDTH-1:0] dout_weight_real,
  output logic [WIDTH-1:0] dout_weight_imag,
  output logic             busy,
  output logic             done,
  output logic             weight_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_DRAIN
  } state_t;

  // First address issued by a load: the highest weight index.
  localparam logic [AW-1:0] LAST_ADDR = AW'(NW - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  // DRAIN lasts exactly two cycles; this flag marks the second one.
  logic            drain_q, drain_d;
  logic            accept;
  logic            finish;

  logic             rd_en_d1_q;
  logic             valid_q;
  logic [WIDTH-1:0] real_q;
  logic [WIDTH-1:0] imag_q;
  logic             done_q;
  logic             ready_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, independent of the
  // order in which the simulator evaluates the always blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; without it, any path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    accept  = 1'b0;
    finish  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // start is only looked at here, so requests during a load are dropped.
        if (start) begin
          accept = 1'b1;
          if (fft_busy) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_READ;
            cnt_d   = LAST_ADDR;
          end
        end
      end

      S_WAIT: begin
        if (!fft_busy) begin
          state_d = S_READ;
          cnt_d   = LAST_ADDR;
        end
      end

      S_READ: begin
        // Exit on the cycle address 0 is issued, so the counter never wraps.
        if (cnt_q == '0) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DRAIN: begin
        // Two cycles: ROM data for address 0 is captured, then emitted.
        if (drain_q) begin
          state_d = S_IDLE;
          drain_d = 1'b0;
          finish  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rom_rd_en = (state_q == S_READ);
  assign rom_addr  = cnt_q;
  assign busy      = (state_q != S_IDLE);

  // ---------------------------------------------------------------------------
  // Output pipe: ROM read strobe -> data-valid -> registered weight
  // ---------------------------------------------------------------------------
  // NOTE: the weight data registers are reset even though they are datapath,
  // because every output of the block must read 0 while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_d1_q <= 1'b0;
      valid_q    <= 1'b0;
      real_q     <= '0;
      imag_q     <= '0;
    end else begin
      rd_en_d1_q <= rom_rd_en;
      valid_q    <= rd_en_d1_q;
      if (rd_en_d1_q) begin
        real_q <= rom_data_real;
        imag_q <= rom_data_imag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completion and buffer coherence flags
  // ---------------------------------------------------------------------------
  // weight_ready drops as soon as a load is accepted because the buffer starts
  // shifting soon after and is incoherent until the final weight lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        ready_q <= 1'b0;
      end else if (finish) begin
        ready_q <= 1'b1;
      end
    end
  end

  assign dout_weight_valid = valid_q;
  assign dout_weight_real  = real_q;
  assign dout_weight_imag  = imag_q;
  assign done              = done_q;
  assign weight_ready      = ready_q;

endmodule

// File: tb/tb_twiddle_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_twiddle_load_ctrl
//
// Bench for twiddle_load_ctrl. Surrounds the DUT with a synchronous ROM and an
// LSB-entry weight shift buffer. A timeline model (cycles since the first read
// of a load) predicts every output; a scoreboard queue holds the ROM words that
// must come out of the pipe. Directed scenarios add literal cycle-number
// expectations, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_twiddle_load_ctrl;

  localparam int NPOINT = 3;
  localparam int WIDTH  = 16;
  localparam int NW     = NPOINT * (1 << (NPOINT - 1));
  localparam int AW     = $clog2(NW);

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_LOAD = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start = 1'b0;
  logic             fft_busy = 1'b0;
  logic             rom_rd_en;
  logic [AW-1:0]    rom_addr;
  logic [WIDTH-1:0] rom_data_real = '0;
  logic [WIDTH-1:0] rom_data_imag = '0;
  logic             dout_weight_valid;
  logic [WIDTH-1:0] dout_weight_real;
  logic [WIDTH-1:0] dout_weight_imag;
  logic             busy;
  logic             done;
  logic             weight_ready;

  int n_checks = 0;
  int n_errors = 0;

  twiddle_load_ctrl #(.NPOINT(NPOINT), .WIDTH(WIDTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .fft_busy          (fft_busy),
    .rom_rd_en         (rom_rd_en),
    .rom_addr          (rom_addr),
    .rom_data_real     (rom_data_real),
    .rom_data_imag     (rom_data_imag),
    .dout_weight_valid (dout_weight_valid),
    .dout_weight_real  (dout_weight_real),
    .dout_weight_imag  (dout_weight_imag),
    .busy              (busy),
    .done              (done),
    .weight_ready      (weight_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Environment: synchronous ROM and LSB-entry weight shift buffer
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rom_re [NW];
  logic [WIDTH-1:0] rom_im [NW];
  logic [WIDTH-1:0] wbuf_re [NW];
  logic [WIDTH-1:0] wbuf_im [NW];

  always @(posedge clk) begin
    if (rom_rd_en) begin
      rom_data_real <= rom_re[rom_addr];
      rom_data_imag <= rom_im[rom_addr];
    end
  end

  always @(posedge clk) begin
    if (dout_weight_valid) begin
      for (int k = NW - 1; k > 0; k--) begin
        wbuf_re[k] <= wbuf_re[k-1];
        wbuf_im[k] <= wbuf_im[k-1];
      end
      wbuf_re[0] <= dout_weight_real;
      wbuf_im[0] <= dout_weight_imag;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model. A load is "waiting" until fft_busy is low, then the
  // timeline t counts cycles from the first read: reads at t=0..NW-1, weights
  // out at t=2..NW+1, done in the cycle after t=NW+1.
  // ---------------------------------------------------------------------------
  int                     m_mode  = M_IDLE;
  int                     m_t     = 0;
  bit                     m_done  = 1'b0;
  bit                     m_ready = 1'b0;
  logic [2*WIDTH-1:0]     exp_q [$];
  logic [2*WIDTH-1:0]     m_img [NW];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  = M_IDLE;
      m_t     = 0;
      m_done  = 1'b0;
      m_ready = 1'b0;
      exp_q.delete();
    end else begin
      // Effects of the cycle that just ended.
      if (m_mode == M_LOAD && m_t < NW)
        exp_q.push_back({rom_re[NW-1-m_t], rom_im[NW-1-m_t]});
      if (m_mode == M_LOAD && m_t >= 2 && exp_q.size() > 0)
        m_img[NW+1-m_t] = exp_q.pop_front();
      // Prediction for the next cycle.
      m_done = 1'b0;
      case (m_mode)
        M_IDLE: begin
          if (start) begin
            m_ready = 1'b0;
            m_mode  = fft_busy ? M_WAIT : M_LOAD;
            m_t     = 0;
          end
        end
        M_WAIT: begin
          if (!fft_busy) begin
            m_mode = M_LOAD;
            m_t    = 0;
          end
        end
        default: begin
          if (m_t == NW + 1) begin
            m_mode  = M_IDLE;
            m_done  = 1'b1;
            m_ready = 1'b1;
          end else begin
            m_t++;
          end
        end
      endcase
    end
  end

  // Compare process: every output, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", busy, 0);
      check("rst_rd_en", rom_rd_en, 0);
      check("rst_addr", rom_addr, 0);
      check("rst_valid", dout_weight_valid, 0);
      check("rst_real", dout_weight_real, 0);
      check("rst_imag", dout_weight_imag, 0);
      check("rst_done", done, 0);
      check("rst_ready", weight_ready, 0);
    end else begin
      check("busy", busy, (m_mode != M_IDLE));
      check("rd_en", rom_rd_en, (m_mode == M_LOAD && m_t < NW));
      check("valid", dout_weight_valid, (m_mode == M_LOAD && m_t >= 2));
      check("done", done, m_done);
      check("weight_ready", weight_ready, m_ready);
      if (m_mode == M_LOAD && m_t < NW)
        check("rom_addr", rom_addr, NW - 1 - m_t);
      if (m_mode == M_LOAD && m_t >= 2) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_nonempty", 0, 1);
        end else begin
          check("weight_real", dout_weight_real, exp_q[0][2*WIDTH-1:WIDTH]);
          check("weight_imag", dout_weight_imag, exp_q[0][WIDTH-1:0]);
        end
      end
      if (m_done) begin
        for (int k = 0; k < NW; k++) begin
          check("buf_real", wbuf_re[k], m_img[k][2*WIDTH-1:WIDTH]);
          check("buf_imag", wbuf_im[k], m_img[k][WIDTH-1:0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 2 time units after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic load_default_image();
    for (int i = 0; i < NW; i++) begin
      rom_re[i] = WIDTH'(i);
      rom_im[i] = WIDTH'(16'h0100 + i);
    end
  endtask

  task automatic load_alt_image();
    for (int i = 0; i < NW; i++) begin
      rom_re[i] = WIDTH'(16'hA000 + 3 * i);
      rom_im[i] = WIDTH'(16'h5000 - i);
    end
  endtask

  task automatic idle_cycles(input int n);
    start = 1'b0;
    repeat (n) next_cycle();
  endtask

  int n_valid;
  int n_done;

  initial begin
    rst_n = 1'b0;
    load_default_image();
    for (int k = 0; k < NW; k++) begin
      wbuf_re[k] = '0;
      wbuf_im[k] = '0;
    end
    repeat (3) next_cycle();
    sample();
    check("reset_busy_lit", busy, 0);
    check("reset_ready_lit", weight_ready, 0);
    next_cycle();
    rst_n = 1'b1;
    idle_cycles(2);

    // Basic load: start accepted in cycle 0.
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      start = 1'b0;
      sample();
      if (c == 1)  check("basic_addr_c1", {rom_rd_en, 4'(rom_addr)}, {1'b1, 4'd11});
      if (c == 12) check("basic_addr_c12", {rom_rd_en, 4'(rom_addr)}, {1'b1, 4'd0});
      if (c == 2)  check("basic_valid_c2", dout_weight_valid, 0);
      if (c == 3)  check("basic_first_w", {dout_weight_valid, dout_weight_real}, {1'b1, 16'd11});
      if (c == 14) check("basic_last_w", {dout_weight_valid, dout_weight_real}, {1'b1, 16'd0});
      if (c == 15) check("basic_done_c15", {done, weight_ready, busy}, 3'b110);
      if (c == 16) check("basic_done_c16", {done, weight_ready}, 2'b01);
    end
    check("basic_slice5_re", wbuf_re[5], 16'd5);
    check("basic_slice5_im", wbuf_im[5], 16'h0105);
    check("basic_slice11_re", wbuf_re[11], 16'd11);
    idle_cycles(3);

    // Deferred start: fft_busy high in cycles -2..2, start in cycle 0.
    fft_busy = 1'b1;
    idle_cycles(2);
    start = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      next_cycle();
      start = 1'b0;
      if (c == 3) fft_busy = 1'b0;
      sample();
      if (c >= 1 && c <= 3) check("defer_wait", {busy, rom_rd_en}, 2'b10);
      if (c == 4)  check("defer_first_rd", {rom_rd_en, 4'(rom_addr)}, {1'b1, 4'd11});
      if (c == 17) check("defer_no_done", done, 0);
      if (c == 18) check("defer_done", {done, weight_ready}, 2'b11);
    end
    idle_cycles(2);

    // Start while busy: second pulse in cycle 6 is ignored.
    n_valid = 0;
    n_done  = 0;
    start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      next_cycle();
      start = (c == 6);
      sample();
      n_valid += int'(dout_weight_valid);
      n_done  += int'(done);
    end
    check("busy_start_valids", n_valid, 12);
    check("busy_start_dones", n_done, 1);
    idle_cycles(2);

    // Back-to-back: start held high; reload accepted in the done cycle.
    start = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      next_cycle();
      sample();
      if (c == 15) check("b2b_done1", {done, weight_ready}, 2'b11);
      if (c == 16) check("b2b_reload", {busy, weight_ready}, 2'b10);
      if (c == 30) check("b2b_done2", {done, weight_ready}, 2'b11);
    end
    idle_cycles(3);

    // Reset mid-load in cycle 7, then a clean full load.
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {busy, rom_rd_en, dout_weight_valid, done, weight_ready}, 5'b0);
    check("midrst_data", {dout_weight_real, dout_weight_imag}, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    idle_cycles(2);
    start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      next_cycle();
      start = 1'b0;
      sample();
      if (c == 15) check("post_rst_done", {done, weight_ready}, 2'b11);
    end
    check("post_rst_slice0", {wbuf_re[0], wbuf_im[0]}, {16'd0, 16'h0100});
    idle_cycles(2);

    // Reload after ready with a different ROM image.
    load_alt_image();
    start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      next_cycle();
      start = 1'b0;
      sample();
      if (c == 1)  check("reload_ready_drop", weight_ready, 0);
      if (c == 15) check("reload_done", {done, weight_ready}, 2'b11);
    end
    check("reload_slice3", {wbuf_re[3], wbuf_im[3]}, {16'hA009, 16'h4FFD});
    idle_cycles(2);

    // Randomized phase: start, fft_busy, ROM contents and reset all vary.
    for (int n = 0; n < 4000; n++) begin
      next_cycle();
      start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 6) == 0) fft_busy = ~fft_busy;
      if ($urandom_range(0, 3) == 0) begin
        int a;
        a = $urandom_range(0, NW - 1);
        rom_re[a] = WIDTH'($urandom);
        rom_im[a] = WIDTH'($urandom);
      end
      rst_n = ($urandom_range(0, 599) != 0);
    end
    rst_n = 1'b1;
    idle_cycles(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/twiddle_load_ctrl.md
# twiddle_load_ctrl

Sequencer that fills the full-parallel FFT twiddle weight shift buffer from a synchronous twiddle ROM. On a start request it reads all NW = NPOINT * 2^(NPOINT-1) complex weights and emits them as a valid-qualified stream that the buffer shifts in. It orders the reads so that weight index k ends in slice k of the buffer's flat weight vectors (bits [k*WIDTH +: WIDTH]). The block sits between the top-level configuration logic, the twiddle ROM and the weight buffer. It holds off loading while the FFT core is computing.

## Interface
- NPOINT, 3, log2 of FFT size; NW = NPOINT * 2^(NPOINT-1) weights (12 at default)
- WIDTH, 16, bits per real/imag component
- AW, derived, $clog2(NW), ROM address width (4 at default)
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous reset, active low
- start  input  1  load request, sampled each cycle
- fft_busy  input  1  FFT core computing; a load must not begin while high
- rom_rd_en  output  1  ROM read strobe
- rom_addr  output  AW  ROM read address
- rom_data_real  input  WIDTH  ROM real data, valid one cycle after rom_rd_en
- rom_data_imag  input  WIDTH  ROM imag data, same timing
- dout_weight_valid  output  1  shift strobe to the weight buffer
- dout_weight_real  output  WIDTH  registered weight real part
- dout_weight_imag  output  WIDTH  registered weight imag part
- busy  output  1  load in progress (WAIT, READ or DRAIN)
- done  output  1  one-cycle pulse when the last weight has been shifted
- weight_ready  output  1  buffer holds a complete, coherent weight set

## Operation
- States: IDLE, WAIT, READ, DRAIN.
- IDLE with start=1:
  - fft_busy=0 → READ.
  - fft_busy=1 → WAIT.
- WAIT: go to READ in the first cycle in which fft_busy is sampled 0. start is ignored while in WAIT.
- READ:
  - rom_rd_en=1 every cycle.
  - rom_addr = NW-1 on entry, then decrements by 1 each cycle.
  - After issuing address 0, go to DRAIN.
  - Exactly NW reads, with no gaps.
- DRAIN: lasts 2 cycles while the last ROM data is registered and emitted, then → IDLE with done=1 for one cycle.
- Output pipe:
  - rd_en_d1 = rom_rd_en delayed one cycle.
  - dout_weight_valid, dout_weight_real and dout_weight_imag are registered from rd_en_d1, rom_data_real and rom_data_imag.
  - Data registers load only when rd_en_d1=1; otherwise they hold their value.
- Order: descending addresses into an LSB-entry shift buffer. Address 0 enters last and ends at slice 0; address NW-1 ends at slice NW-1.
- weight_ready:
  - Cleared on the cycle the block leaves IDLE, i.e. when start is accepted.
  - Set together with done.
  - Otherwise holds its value.
- start while busy=1: ignored, no queuing.
- start in the done cycle (state is IDLE): accepted normally.
- fft_busy rising during READ/DRAIN: ignored; the load runs to completion. Upstream must not start the core while weight_ready=0.
- Counter: AW-bit down-counter. No wrap occurs because READ exits on count==0.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0; rd_en_d1 0.
- Reset asserted mid-load: immediate return to IDLE with all outputs 0. The partially filled buffer is flagged not ready (weight_ready=0).
- Default-case timeline, with start accepted in cycle 0 (fft_busy=0):
  - READ cycles 1..NW; rom_addr = NW-1..0.
  - ROM data in cycles 2..NW+1.
  - dout_weight_valid in cycles 3..NW+2.
  - done and weight_ready in cycle NW+3.
- busy high in cycles 1..NW+2, i.e. in every WAIT, READ and DRAIN cycle.
- Latency start→done = NW+3 cycles, plus the number of cycles spent in WAIT.
- Throughput: one weight per cycle; no backpressure.

## Test plan
- Basic load, NW=12, ROM[i] = (i, 0x100+i), start pulse with fft_busy=0:
  - rom_addr sequence 11..0 in cycles 1..12.
  - valid in cycles 3..14, real values 11..0.
  - done=1 and weight_ready=1 in cycle 15.
  - Buffer slice k = (k, 0x100+k).
- Deferred start: fft_busy=1 for 5 cycles around the start pulse:
  - busy=1 and rom_rd_en=0 throughout WAIT.
  - First read is in the cycle after fft_busy is sampled 0.
  - done comes 15 cycles after leaving WAIT.
- Start while busy: a second start pulse at cycle 6 → no effect; exactly 12 valids; a single done pulse.
- Back-to-back: start held high continuously → a new load is accepted in the done cycle; weight_ready pulses 1 for one cycle, then is 0 during the reload.
- Reset mid-load: rst_n=0 at cycle 7 → all outputs 0 immediately, weight_ready=0. A subsequent start produces a full clean 12-weight load.
- Reload after ready: a second load with a different ROM image → weight_ready drops at acceptance, and the buffer matches the new image after done.
